// File: rtl/count_readout_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : count_readout_pkg
//  Description : Shared types, record geometry and byte-select helper for the
//                count readout path.
//  Revision    : 1.0  initial release
// ============================================================================
package count_readout_pkg;

  // Default geometry: 4 channels of 32-bit counts, 4 records deep
  localparam int N_CH_DEF  = 4;
  localparam int CNT_W_DEF = 32;
  localparam int DEPTH_DEF = 4;

  // Widest record the byte helper can address (128 bytes)
  localparam int REC_MAX_W = 1024;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    READY  = 2'd1,
    STREAM = 2'd2
  } rd_state_t;

  // Record width in bits: time word followed by every channel count
  function automatic int rec_w(input int n_ch, input int cnt_w);
    return (n_ch + 1) * cnt_w;
  endfunction

  // Record length in bytes
  function automatic int rec_bytes(input int n_ch, input int cnt_w);
    return rec_w(n_ch, cnt_w) / 8;
  endfunction

  localparam int REC_W     = rec_w(N_CH_DEF, CNT_W_DEF);
  localparam int REC_BYTES = rec_bytes(N_CH_DEF, CNT_W_DEF);

  // Little-endian byte select: idx 0 returns rec[7:0]
  function automatic logic [7:0] byte_of(input logic [REC_MAX_W-1:0] rec,
                                         input logic [6:0]           idx);
    return rec[{idx, 3'b000} +: 8];
  endfunction

endpackage
`default_nettype wire

// File: rtl/count_readout_if.sv
`default_nettype none
// ============================================================================
//  Module      : count_readout_if
//  Description : Host read bus of the count readout: byte strobe, record
//                discard, returned byte and FIFO status.
//  Revision    : 1.0  initial release
// ============================================================================
interface count_readout_if #(
  parameter int DEPTH = 4
);
  logic                     rd;
  logic                     pop;
  logic [7:0]               rd_data;
  logic                     rd_valid;
  logic [$clog2(DEPTH):0]   level;
  logic                     empty;
  logic                     full;
  logic                     overflow;

  // Host side drives the strobes and observes data/status
  modport master (
    output rd, pop,
    input  rd_data, rd_valid, level, empty, full, overflow
  );

  // Readout side serves the strobes
  modport slave (
    input  rd, pop,
    output rd_data, rd_valid, level, empty, full, overflow
  );
endinterface
`default_nettype wire

// File: rtl/snapshot_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : snapshot_fifo
//  Description : Register-based record FIFO. A write while full is accepted
//                only when the head is popped in the same cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module snapshot_fifo #(
  parameter int WIDTH = 160,
  parameter int DEPTH = 4
) (
  input  wire logic                     clk,
  input  wire logic                     nRESET,
  input  wire logic                     init_i,
  input  wire logic                     wr_i,
  input  wire logic [WIDTH-1:0]         wdata_i,
  input  wire logic                     pop_i,
  output logic      [WIDTH-1:0]         rdata_o,
  output logic      [$clog2(DEPTH):0]   level_o,
  output logic                          full_o,
  output logic                          empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [LW-1:0]    level_q;

  logic w_pop;
  logic w_wr;

  assign w_pop = pop_i && (level_q != '0);
  assign w_wr  = wr_i && ((level_q != LW'(DEPTH)) || w_pop);

  // Record storage; contents are don't-care until written so no reset
  always_ff @(posedge clk) begin
    if (w_wr) mem_q[wptr_q] <= wdata_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else if (init_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (w_wr)  wptr_q <= wptr_q + 1'b1;
      if (w_pop) rptr_q <= rptr_q + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  assign rdata_o = mem_q[rptr_q];
  assign level_o = level_q;
  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);

endmodule
`default_nettype wire

// File: rtl/count_readout.sv
`default_nettype none
// ============================================================================
//  Module      : count_readout
//  Description : Captures time/channel snapshots into a record FIFO and
//                streams the head record to the host one byte per read strobe.
//  Revision    : 1.0  initial release
// ============================================================================
module count_readout
  import count_readout_pkg::*;
#(
  parameter int N_CH  = N_CH_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  wire logic                    clk,
  input  wire logic                    nRESET,
  input  wire logic                    init,
  input  wire logic                    snap,
  input  wire logic [CNT_W-1:0]        time_in,
  input  wire logic [N_CH*CNT_W-1:0]   cnt_in,
  count_readout_if.slave               host
);

  localparam int RW    = rec_w(N_CH, CNT_W);
  localparam int RB    = rec_bytes(N_CH, CNT_W);
  localparam int PTR_W = $clog2(RB);
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(RB - 1);

  rd_state_t         state_q;
  logic [PTR_W-1:0]  ptr_q;
  logic [7:0]        rd_data_q;
  logic              rd_valid_q;
  logic              overflow_q;

  logic [RW-1:0]     w_wrec;
  logic [RW-1:0]     w_head;
  logic [LW-1:0]     w_level;
  logic [LW-1:0]     w_level_after;
  logic              w_full;
  logic              w_empty;
  logic              w_has;
  logic              w_last;
  logic              w_head_pop;
  logic              w_wr;
  logic [7:0]        w_byte;

  // Time word occupies the low bytes, channel 0 follows it
  assign w_wrec = {cnt_in, time_in};

  assign w_has      = (state_q != EMPTY);
  assign w_last     = (ptr_q == LAST_PTR);
  // A same-cycle rd and pop still drops only one record
  assign w_head_pop = w_has && ((host.rd && w_last) || host.pop);
  // The slot freed by a head pop may be reused in the same cycle
  assign w_wr       = snap && (!w_full || w_head_pop);
  assign w_level_after = w_level + LW'(w_wr) - LW'(w_head_pop);

  assign w_byte = byte_of(REC_MAX_W'(w_head), 7'(ptr_q));

  snapshot_fifo #(
    .WIDTH (RW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .nRESET  (nRESET),
    .init_i  (init),
    .wr_i    (w_wr),
    .wdata_i (w_wrec),
    .pop_i   (w_head_pop),
    .rdata_o (w_head),
    .level_o (w_level),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  // Read FSM, byte pointer, returned byte and sticky overflow
  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      state_q    <= EMPTY;
      ptr_q      <= '0;
      rd_data_q  <= 8'h00;
      rd_valid_q <= 1'b0;
      overflow_q <= 1'b0;
    end else if (init) begin
      state_q    <= EMPTY;
      ptr_q      <= '0;
      rd_data_q  <= 8'h00;
      rd_valid_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      rd_valid_q <= host.rd;
      if (host.rd) rd_data_q <= w_has ? w_byte : 8'h00;
      if (snap && !w_wr) overflow_q <= 1'b1;

      case (state_q)
        EMPTY: begin
          if (w_wr) state_q <= READY;
        end
        READY: begin
          if (w_head_pop) begin
            ptr_q   <= '0;
            state_q <= (w_level_after != '0) ? READY : EMPTY;
          end else if (host.rd) begin
            ptr_q   <= ptr_q + 1'b1;
            state_q <= STREAM;
          end
        end
        STREAM: begin
          if (w_head_pop) begin
            ptr_q   <= '0;
            state_q <= (w_level_after != '0) ? READY : EMPTY;
          end else if (host.rd) begin
            ptr_q   <= ptr_q + 1'b1;
          end
        end
        default: begin
          ptr_q   <= '0;
          state_q <= EMPTY;
        end
      endcase
    end
  end

  assign host.rd_data  = rd_data_q;
  assign host.rd_valid = rd_valid_q;
  assign host.level    = w_level;
  assign host.empty    = w_empty;
  assign host.full     = w_full;
  assign host.overflow = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_count_readout.sv
`default_nettype none
// ============================================================================
//  Module      : tb_count_readout
//  Description : Directed bench for count_readout with a record-queue model
//                and an expected-byte scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_count_readout;

  localparam int N_CH  = 4;
  localparam int CNT_W = 32;
  localparam int DEPTH = 4;
  localparam int RB    = 20;

  logic         clk     = 1'b0;
  logic         nRESET  = 1'b0;
  logic         init    = 1'b0;
  logic         snap    = 1'b0;
  logic [31:0]  time_in = '0;
  logic [127:0] cnt_in  = '0;

  count_readout_if #(.DEPTH(DEPTH)) bus ();

  count_readout #(
    .N_CH  (N_CH),
    .CNT_W (CNT_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk     (clk),
    .nRESET  (nRESET),
    .init    (init),
    .snap    (snap),
    .time_in (time_in),
    .cnt_in  (cnt_in),
    .host    (bus)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: stored records, head byte pointer, sticky overflow
  logic [159:0] mrec[$];
  int           mptr = 0;
  logic         movf = 1'b0;
  // Scoreboard of bytes the host should receive
  logic [7:0]   exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_status(input string tag);
    chk({tag, ".level"},    32'(bus.level),    32'(mrec.size()));
    chk({tag, ".empty"},    32'(bus.empty),    32'(mrec.size() == 0));
    chk({tag, ".full"},     32'(bus.full),     32'(mrec.size() == DEPTH));
    chk({tag, ".overflow"}, 32'(bus.overflow), 32'(movf));
  endtask

  function automatic logic [159:0] mk_rec(input logic [31:0] t, input logic [127:0] c);
    return {c, t};
  endfunction

  // One clock cycle of stimulus, model update and output comparison
  task automatic cycle(input string tag, input bit s, input bit r, input bit p,
                       input logic [31:0] t = 32'h0, input logic [127:0] c = 128'h0);
    bit           has;
    bit           hp;
    logic [159:0] hr;
    logic [7:0]   b;
    @(negedge clk);
    snap = s; bus.rd = r; bus.pop = p;
    if (s) begin time_in = t; cnt_in = c; end
    has = (mrec.size() > 0);
    hp  = has && ((r && mptr == RB - 1) || p);
    if (r) begin
      b = 8'h00;
      if (has) begin hr = mrec[0]; b = hr[mptr*8 +: 8]; end
      exp_q.push_back(b);
    end
    if (hp) begin void'(mrec.pop_front()); mptr = 0; end
    else if (r && has) mptr++;
    if (s) begin
      if (mrec.size() < DEPTH) mrec.push_back(mk_rec(t, c));
      else movf = 1'b1;
    end
    @(posedge clk); #1;
    snap = 1'b0; bus.rd = 1'b0; bus.pop = 1'b0;
    if (r) begin
      chk({tag, ".rd_valid"}, 32'(bus.rd_valid), 32'd1);
      chk({tag, ".rd_data"},  32'(bus.rd_data),  32'(exp_q.pop_front()));
    end else begin
      chk({tag, ".rd_valid_idle"}, 32'(bus.rd_valid), 32'd0);
    end
    chk_status(tag);
  endtask

  task automatic do_snap(input string tag);
    cycle(tag, 1'b1, 1'b0, 1'b0, $urandom, {$urandom, $urandom, $urandom, $urandom});
  endtask

  task automatic do_reads(input string tag, input int n);
    for (int i = 0; i < n; i++) cycle(tag, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic do_init(input string tag);
    @(negedge clk);
    init = 1'b1;
    @(posedge clk); #1;
    init = 1'b0;
    mrec.delete(); mptr = 0; movf = 1'b0;
    chk({tag, ".rd_valid"}, 32'(bus.rd_valid), 32'd0);
    chk({tag, ".rd_data"},  32'(bus.rd_data),  32'd0);
    chk_status(tag);
  endtask

  initial begin
    bus.rd  = 1'b0;
    bus.pop = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset.rd_data",  32'(bus.rd_data),  32'd0);
    chk("reset.rd_valid", 32'(bus.rd_valid), 32'd0);
    chk_status("reset");
    @(negedge clk) nRESET = 1'b1;

    // 1: one known record streamed out byte by byte
    cycle("t1.snap", 1'b1, 1'b0, 1'b0, 32'h0000_0100,
          {32'd4, 32'd3, 32'd2, 32'd1});
    do_reads("t1.rd", RB);
    chk("t1.empty_after", 32'(bus.empty), 32'd1);

    // 2: fill, drop the fifth snap, drain in order, init clears overflow
    for (int i = 0; i < 5; i++) do_snap("t2.snap");
    do_reads("t2.drain", RB * DEPTH);
    do_init("t2.init");

    // 3: full FIFO, snap coincident with the last byte of the head
    for (int i = 0; i < DEPTH; i++) do_snap("t3.fill");
    do_reads("t3.rd", RB - 1);
    cycle("t3.last_snap", 1'b1, 1'b1, 1'b0, 32'hCAFE_F00D,
          {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111});
    chk("t3.level4", 32'(bus.level), 32'd4);
    do_reads("t3.rd2", 5);
    do_init("t3.init");

    // 4: partial read then pop moves to the next record
    do_snap("t4.snap");
    do_snap("t4.snap");
    do_reads("t4.rd", 3);
    cycle("t4.pop", 1'b0, 1'b0, 1'b1);
    do_reads("t4.rd_next", 2);
    // rd together with pop: byte from current head, then single pop
    do_snap("t4.snap3");
    cycle("t4.rd_pop", 1'b0, 1'b1, 1'b1);
    do_reads("t4.rd_after", 1);
    do_init("t4.init");

    // 5: empty read, empty pop, snap with rd while empty
    cycle("t5.rd_empty", 1'b0, 1'b1, 1'b0);
    cycle("t5.pop_empty", 1'b0, 1'b0, 1'b1);
    cycle("t5.snap_rd", 1'b1, 1'b1, 1'b0, $urandom, {$urandom, $urandom, $urandom, $urandom});
    do_reads("t5.rd", 2);
    do_init("t5.init");

    // 6: asynchronous reset in the middle of a record
    do_snap("t6.snap");
    do_snap("t6.snap");
    do_reads("t6.rd", 7);
    #3;
    nRESET = 1'b0;
    #1;
    mrec.delete(); mptr = 0; movf = 1'b0;
    chk("t6.rst.rd_data",  32'(bus.rd_data),  32'd0);
    chk("t6.rst.rd_valid", 32'(bus.rd_valid), 32'd0);
    chk_status("t6.rst");
    @(negedge clk) nRESET = 1'b1;
    do_snap("t6.new");
    do_reads("t6.rd_new", 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
